digit_counter: RTL

DIGIT_COUNTER -- requirements
Module: digit_counter

---
 rtl/digit_counter_pkg.sv | 72 +++++++
 rtl/digit_counter_if.sv | 23 ++
 rtl/digit_counter_key_debounce.sv | 84 ++++++++
 rtl/digit_counter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/digit_counter_pkg.sv
// digit_counter_pkg: shared types, sizes and BCD helpers for the 4-digit
// up/down push-button counter.
package digit_counter_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int CNT_W      = DIGIT_W * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UP_HELD  = 2'd1,
    DN_HELD  = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  // Ripple BCD increment; bit CNT_W is the carry out of the top digit.
  function automatic logic [CNT_W:0] bcd_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    logic             c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
          r[i*DIGIT_W +: DIGIT_W] = 4'd0;
        end else begin
          r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W];
      end
    end
    return {c, r};
  endfunction

  // Ripple BCD decrement; bit CNT_W is the borrow out of the top digit.
  function automatic logic [CNT_W:0] bcd_dec(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    logic             b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[i*DIGIT_W +: DIGIT_W] == 4'd0) begin
          r[i*DIGIT_W +: DIGIT_W] = 4'd9;
        end else begin
          r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W] - 4'd1;
          b = 1'b0;
        end
      end else begin
        r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W];
      end
    end
    return {b, r};
  endfunction

  // Clamp every nibble above 9 to 9 so the count always stays valid BCD.
  function automatic logic [CNT_W-1:0] bcd_sat(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > 4'd9) begin
        r[i*DIGIT_W +: DIGIT_W] = 4'd9;
      end else begin
        r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_counter_if.sv
// digit_counter_if: key, load and display signals of the digit counter.
// master = the board/environment side, slave = the counter itself.
interface digit_counter_if;
  import digit_counter_pkg::*;

  logic             KEY_UP;
  logic             KEY_DN;
  logic             LOAD;
  logic [CNT_W-1:0] LOAD_VAL;
  logic [CNT_W-1:0] DIGITS;
  logic             CARRY;
  logic             STEP;

  modport master (
    output KEY_UP, KEY_DN, LOAD, LOAD_VAL,
    input  DIGITS, CARRY, STEP
  );

  modport slave (
    input  KEY_UP, KEY_DN, LOAD, LOAD_VAL,
    output DIGITS, CARRY, STEP
  );
endinterface

// File: rtl/digit_counter_key_debounce.sv
// key_debounce: 2-flop synchronizer plus stable-sample counter for one
// active-low push-button. After reset the key must first be seen released
// for DEBOUNCE_CYCLES samples before any press is reported, so a button held
// through reset never produces a spurious press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Next-state: synchronize, then accept a change only after a full stable run.
  always_comb begin
    sync1_d   = key_n_i;
    sync2_d   = sync1_q;
    cnt_d     = cnt_q;
    db_d      = db_q;
    armed_d   = armed_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (!armed_q) begin
      if (sync2_q) begin
        if (cnt_q == LIMIT_M1) begin
          armed_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end else if (sync2_q != db_q) begin
      if (cnt_q == LIMIT_M1) begin
        db_d      = sync2_q;
        cnt_d     = '0;
        press_d   = ~sync2_q;
        release_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers; reset parks everything at the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      db_q      <= 1'b1;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = db_q;
  assign press_o   = press_q;
  assign release_o = release_q;
endmodule

// File: rtl/digit_counter.sv
// digit_counter: 4-digit BCD up/down counter driven by two debounced
// push-buttons, with synchronous load. Optional auto-repeat while a key is
// held is enabled by defining DIGIT_COUNTER_AUTO_REPEAT_EN.
module digit_counter
  import digit_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic            CLOCK_50,
  input  logic            RESET,
  digit_counter_if.slave  bus
);
  logic up_lvl_s, up_press_s, up_rel_s;
  logic dn_lvl_s, dn_press_s, dn_rel_s;
  logic rpt_fire_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] digits_q, digits_d;
  logic             step_q, step_d;
  logic             carry_q, carry_d;
  logic             do_up_s, do_dn_s;
  logic [CNT_W:0]   inc_s, dec_s;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_deb (
    .clk(CLOCK_50), .rst(RESET), .key_n_i(bus.KEY_UP),
    .level_o(up_lvl_s), .press_o(up_press_s), .release_o(up_rel_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_deb (
    .clk(CLOCK_50), .rst(RESET), .key_n_i(bus.KEY_DN),
    .level_o(dn_lvl_s), .press_o(dn_press_s), .release_o(dn_rel_s)
  );

`ifdef DIGIT_COUNTER_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_phase_q, rpt_phase_d;
  logic [RPT_W-1:0] rpt_limit_s;

  // Repeat timer: first fire after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_fire_s  = 1'b0;
    rpt_limit_s = rpt_phase_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
    if ((state_q == UP_HELD) || (state_q == DN_HELD)) begin
      if (rpt_cnt_q == rpt_limit_s) begin
        rpt_fire_s  = 1'b1;
        rpt_cnt_d   = '0;
        rpt_phase_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end else begin
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
    end
  end

  // Repeat timer registers.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`else
  // No repeat hardware; the repeat parameters stay in the parameter list so
  // both builds instantiate identically, and fold to a constant 0 here.
  assign rpt_fire_s = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

  assign inc_s = bcd_inc(digits_q);
  assign dec_s = bcd_dec(digits_q);

  // Key FSM and count update; LOAD wins over a step, which is then dropped.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    step_d   = 1'b0;
    carry_d  = 1'b0;
    do_up_s  = 1'b0;
    do_dn_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (up_press_s && dn_press_s) begin
          state_d = WAIT_REL;
        end else if (up_press_s) begin
          do_up_s = 1'b1;
          state_d = UP_HELD;
        end else if (dn_press_s) begin
          do_dn_s = 1'b1;
          state_d = DN_HELD;
        end else begin
          state_d = IDLE;
        end
      end
      UP_HELD: begin
        if (dn_press_s) begin
          state_d = WAIT_REL;
        end else if (up_rel_s) begin
          state_d = IDLE;
        end else if (rpt_fire_s) begin
          do_up_s = 1'b1;
        end else begin
          state_d = UP_HELD;
        end
      end
      DN_HELD: begin
        if (up_press_s) begin
          state_d = WAIT_REL;
        end else if (dn_rel_s) begin
          state_d = IDLE;
        end else if (rpt_fire_s) begin
          do_dn_s = 1'b1;
        end else begin
          state_d = DN_HELD;
        end
      end
      WAIT_REL: begin
        if (up_lvl_s && dn_lvl_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_REL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.LOAD) begin
      digits_d = bcd_sat(bus.LOAD_VAL);
    end else if (do_up_s) begin
      digits_d = inc_s[CNT_W-1:0];
      step_d   = 1'b1;
      carry_d  = inc_s[CNT_W];
    end else if (do_dn_s) begin
      digits_d = dec_s[CNT_W-1:0];
      step_d   = 1'b1;
      carry_d  = dec_s[CNT_W];
    end else begin
      digits_d = digits_q;
    end
  end

  // FSM state and registered outputs; reset beats LOAD and key events.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q  <= IDLE;
      digits_q <= '0;
      step_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      step_q   <= step_d;
      carry_q  <= carry_d;
    end
  end

  assign bus.DIGITS = digits_q;
  assign bus.STEP   = step_q;
  assign bus.CARRY  = carry_q;
endmodule
